// File: rtl/pps_ctrl_pkg.sv
// Shared types and default timing constants for the PPS sequencing controller.
package pps_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RESET     = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_SETTLE    = 3'd3,
    ST_WAIT_PPS  = 3'd4,
    ST_RUN       = 3'd5,
    ST_FAULT     = 3'd6
  } state_t;

  localparam int unsigned DEF_RESET_CYCLES  = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT  = 10_000_000;
  localparam int unsigned DEF_SETTLE_CYCLES = 1_000_000;
  localparam int unsigned DEF_PPS_PERIOD    = 100_000_000;
  localparam int unsigned DEF_PPS_TOL       = 1_000;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; both stages clear on reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/pps_ctrl.sv
// Brings the clock wizard / PPS generator out of reset, waits for lock and
// settle, then qualifies and forwards the PPS train, faulting on lock loss or bad period.
module pps_ctrl
  import pps_ctrl_pkg::*;
#(
  parameter int unsigned RESET_CYCLES  = DEF_RESET_CYCLES,
  parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned PPS_PERIOD    = DEF_PPS_PERIOD,
  parameter int unsigned PPS_TOL       = DEF_PPS_TOL
) (
  input  logic        clk100MHz,
  input  logic        areset_n,
  input  logic        mmcm_locked,
  input  logic        arm,
  input  logic        pps_in,
  output logic        gen_reset,
  output logic        pps_out,
  output logic [2:0]  state,
  output logic        fault,
  output logic [31:0] pps_count
);

  localparam logic [31:0] RST_LAST    = 32'(RESET_CYCLES - 1);
  localparam logic [31:0] LOCK_LAST   = 32'(LOCK_TIMEOUT - 1);
  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] WIN_LO      = 32'(PPS_PERIOD - PPS_TOL);
  localparam logic [31:0] WIN_HI      = 32'(PPS_PERIOD + PPS_TOL);

  state_t      state_reg, state_next;
  logic [31:0] cnt_reg, cnt_next;
  logic [31:0] ival_reg, ival_next;
  logic [31:0] count_reg, count_next;
  logic        pps_q_reg;
  logic        pass_reg, pass_next;
  logic        gen_reset_reg;
  logic        fault_reg;
  logic        lock_sync;
  logic        edge_det;
  logic        in_window;
  logic        accept;
  logic        reload;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk      (clk100MHz),
    .areset_n (areset_n),
    .d        (mmcm_locked),
    .q        (lock_sync)
  );

  always_comb begin
    edge_det   = pps_in & ~pps_q_reg;
    in_window  = (ival_reg >= WIN_LO) && (ival_reg <= WIN_HI);
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (arm) begin
          state_next = ST_RESET;
          cnt_next   = '0;
        end
      end
      ST_RESET: begin
        if (cnt_reg == RST_LAST) begin
          state_next = ST_WAIT_LOCK;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 32'd1;
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_sync) begin
          state_next = ST_SETTLE;
          cnt_next   = '0;
        end else if (cnt_reg == LOCK_LAST) begin
          state_next = ST_FAULT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 32'd1;
        end
      end
      ST_SETTLE: begin
        if (!lock_sync) begin
          state_next = ST_WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt_reg == SETTLE_LAST) begin
          state_next = ST_WAIT_PPS;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 32'd1;
        end
      end
      ST_WAIT_PPS: begin
        if (!lock_sync || ival_reg >= WIN_HI) state_next = ST_FAULT;
        else if (edge_det)                    state_next = ST_RUN;
      end
      ST_RUN: begin
        if (!lock_sync || ival_reg > WIN_HI) state_next = ST_FAULT;
        else if (edge_det) begin
          if (in_window) accept     = 1'b1;
          else           state_next = ST_FAULT;
        end
      end
      ST_FAULT: state_next = ST_FAULT;
      default:  state_next = ST_IDLE;
    endcase

    // Dropping arm overrides every other event in every state.
    if (!arm) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
      accept     = 1'b0;
    end

    // The interval counter holds cycles elapsed since the reference edge,
    // so the edge cycle reloads it to 1 and the next edge reads the true period.
    reload    = accept || (state_reg == ST_WAIT_PPS && state_next == ST_RUN);
    ival_next = '0;
    if (state_next == ST_WAIT_PPS || state_next == ST_RUN) begin
      if (reload)
        ival_next = 32'd1;
      else if (state_reg == ST_WAIT_PPS || state_reg == ST_RUN)
        ival_next = sat_inc(ival_reg);
    end

    pass_next  = (state_next == ST_RUN) && pps_in && (pass_reg || accept);
    count_next = (state_next == ST_IDLE) ? 32'd0 : count_reg + {31'd0, accept};
  end

  always_ff @(posedge clk100MHz or negedge areset_n) begin
    if (!areset_n) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      ival_reg      <= '0;
      count_reg     <= '0;
      pps_q_reg     <= 1'b0;
      pass_reg      <= 1'b0;
      gen_reset_reg <= 1'b1;
      fault_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      ival_reg      <= ival_next;
      count_reg     <= count_next;
      pps_q_reg     <= pps_in;
      pass_reg      <= pass_next;
      gen_reset_reg <= (state_next == ST_IDLE) || (state_next == ST_RESET) ||
                       (state_next == ST_FAULT);
      fault_reg     <= (state_next == ST_FAULT);
    end
  end

  // The pass flag only survives while pps_in stays high, so it is the forwarded pulse.
  assign pps_out   = pass_reg;
  assign gen_reset = gen_reset_reg;
  assign fault     = fault_reg;
  assign state     = state_reg;
  assign pps_count = count_reg;

endmodule

// File: tb/tb_pps_ctrl.sv
// Directed bench for pps_ctrl with shortened timing parameters.
module tb_pps_ctrl;
  import pps_ctrl_pkg::*;

  logic        clk100MHz = 1'b0;
  logic        areset_n;
  logic        mmcm_locked;
  logic        arm;
  logic        pps_in;
  logic        gen_reset;
  logic        pps_out;
  logic [2:0]  state_o;
  logic        fault;
  logic [31:0] pps_count;

  int n_checks = 0;
  int n_errors = 0;

  pps_ctrl #(
    .RESET_CYCLES  (4),
    .LOCK_TIMEOUT  (50),
    .SETTLE_CYCLES (20),
    .PPS_PERIOD    (100),
    .PPS_TOL       (5)
  ) dut (
    .clk100MHz   (clk100MHz),
    .areset_n    (areset_n),
    .mmcm_locked (mmcm_locked),
    .arm         (arm),
    .pps_in      (pps_in),
    .gen_reset   (gen_reset),
    .pps_out     (pps_out),
    .state       (state_o),
    .fault       (fault),
    .pps_count   (pps_count)
  );

  always #5 clk100MHz = ~clk100MHz;

  initial begin
    #500000;
    $display("FAIL watchdog state=%0d", state_o);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic check_state(input string tag, input logic [2:0] exp);
    check(tag, 32'(state_o), 32'(exp));
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk100MHz);
      #1;
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int limit, output int n);
    n = 0;
    while (state_o != s && n < limit) begin
      step(1);
      n++;
    end
    if (state_o != s) check("wait_state_timeout", 32'(state_o), 32'(s));
  endtask

  task automatic shut_down();
    arm         = 1'b0;
    mmcm_locked = 1'b0;
    pps_in      = 1'b0;
    step(4);
  endtask

  // From IDLE: arm, release after reset, lock lock_delay cycles later, settle.
  task automatic bring_up(input int lock_delay);
    int n;
    arm = 1'b1;
    check_state("idle_at_arm", ST_IDLE);
    check("gen_reset_at_arm", 32'(gen_reset), 32'd1);
    n = 1;
    step(1);
    check_state("reset_entered", ST_RESET);
    while (gen_reset && n < 40) begin
      n++;
      step(1);
    end
    check("gen_reset_high_cycles", 32'(n), 32'd5);
    check_state("wait_lock_entered", ST_WAIT_LOCK);
    step(lock_delay);
    mmcm_locked = 1'b1;
    wait_state(ST_SETTLE, 10, n);
    check("lock_to_settle", 32'(n), 32'd3);
    wait_state(ST_WAIT_PPS, 40, n);
    check("settle_cycles", 32'(n), 32'd20);
  endtask

  // Rising edge now, 3-cycle pulse, returns d cycles after the rise.
  task automatic pps_edge(input int d, input logic fwd, input string tag);
    pps_in = 1'b1;
    step(1);
    check({tag, "_rise"}, 32'(pps_out), 32'(fwd));
    step(2);
    pps_in = 1'b0;
    check({tag, "_hold"}, 32'(pps_out), 32'(fwd));
    step(1);
    check({tag, "_fall"}, 32'(pps_out), 32'd0);
    step(d - 4);
  endtask

  initial begin
    int n;
    areset_n    = 1'b0;
    arm         = 1'b0;
    mmcm_locked = 1'b0;
    pps_in      = 1'b0;
    step(3);
    check_state("rst_state", ST_IDLE);
    check("rst_gen_reset", 32'(gen_reset), 32'd1);
    check("rst_pps_out", 32'(pps_out), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_count", pps_count, 32'd0);
    areset_n = 1'b1;
    step(2);

    // Nominal bring-up, then tolerance boundaries
    bring_up(10);
    pps_edge(100, 1'b0, "first_edge");
    check_state("run_after_first", ST_RUN);
    check("count_after_first", pps_count, 32'd0);
    repeat (3) pps_edge(100, 1'b1, "nominal");
    check("count_nominal", pps_count, 32'd3);
    pps_edge(95, 1'b1, "iv100");
    pps_edge(105, 1'b1, "iv95");
    pps_edge(94, 1'b1, "iv105");
    check("count_after_bounds", pps_count, 32'd6);
    pps_edge(10, 1'b0, "iv94");
    check_state("iv94_state", ST_FAULT);
    check("iv94_fault", 32'(fault), 32'd1);
    check("iv94_gen_reset", 32'(gen_reset), 32'd1);
    check("iv94_count_held", pps_count, 32'd6);
    step(20);
    check_state("fault_held_armed", ST_FAULT);
    arm = 1'b0;
    step(1);
    check_state("disarm_from_fault", ST_IDLE);
    check("disarm_fault_clr", 32'(fault), 32'd0);
    check("disarm_count_clr", pps_count, 32'd0);

    // Missing edge in RUN
    shut_down();
    bring_up(10);
    pps_edge(100, 1'b0, "run2_first");
    pps_edge(106, 1'b1, "run2_good");
    check_state("still_run_at_106", ST_RUN);
    step(1);
    check_state("no_edge_fault", ST_FAULT);
    check("no_edge_fault_flag", 32'(fault), 32'd1);

    // Lock drop during SETTLE, then in RUN
    shut_down();
    arm = 1'b1;
    wait_state(ST_WAIT_LOCK, 10, n);
    mmcm_locked = 1'b1;
    wait_state(ST_SETTLE, 10, n);
    step(10);
    mmcm_locked = 1'b0;
    wait_state(ST_WAIT_LOCK, 10, n);
    check("settle_drop_latency", 32'(n), 32'd3);
    mmcm_locked = 1'b1;
    wait_state(ST_SETTLE, 10, n);
    wait_state(ST_WAIT_PPS, 40, n);
    check("resettle_cycles", 32'(n), 32'd20);
    pps_edge(50, 1'b0, "run3_first");
    check_state("run3_state", ST_RUN);
    mmcm_locked = 1'b0;
    wait_state(ST_FAULT, 10, n);
    check("run_lock_drop", 32'(n), 32'd3);
    check("run_lock_drop_fault", 32'(fault), 32'd1);

    // Lock never arrives
    shut_down();
    arm = 1'b1;
    wait_state(ST_WAIT_LOCK, 10, n);
    wait_state(ST_FAULT, 60, n);
    check("lock_timeout_cycles", 32'(n), 32'd50);

    // Disarm during a forwarded pulse
    shut_down();
    bring_up(10);
    pps_edge(100, 1'b0, "run4_first");
    pps_in = 1'b1;
    step(1);
    check("fwd_before_disarm", 32'(pps_out), 32'd1);
    check("count_before_disarm", pps_count, 32'd1);
    arm = 1'b0;
    step(1);
    check("disarm_pps_out", 32'(pps_out), 32'd0);
    check_state("disarm_state", ST_IDLE);
    check("disarm_gen_reset", 32'(gen_reset), 32'd1);
    check("disarm_count", pps_count, 32'd0);
    pps_in = 1'b0;

    // Asynchronous reset mid-pulse in RUN
    shut_down();
    bring_up(10);
    pps_edge(100, 1'b0, "run5_first");
    pps_in = 1'b1;
    step(1);
    #2;
    areset_n = 1'b0;
    #1;
    check_state("async_state", ST_IDLE);
    check("async_gen_reset", 32'(gen_reset), 32'd1);
    check("async_pps_out", 32'(pps_out), 32'd0);
    check("async_fault", 32'(fault), 32'd0);
    check("async_count", pps_count, 32'd0);
    arm         = 1'b0;
    pps_in      = 1'b0;
    mmcm_locked = 1'b0;
    #2;
    areset_n = 1'b1;
    step(3);
    check_state("idle_after_reset", ST_IDLE);
    arm = 1'b1;
    step(1);
    check_state("arm_after_reset", ST_RESET);

    // Count wrap
    shut_down();
    bring_up(10);
    pps_edge(100, 1'b0, "run6_first");
    force dut.count_reg = 32'hFFFF_FFFF;
    step(1);
    release dut.count_reg;
    check("wrap_preload", pps_count, 32'hFFFF_FFFF);
    pps_edge(10, 1'b1, "wrap_edge");
    check("wrap_count", pps_count, 32'h0000_0000);
    check("wrap_no_fault", 32'(fault), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pps_ctrl.md
# pps_ctrl

Sequencing and supervision controller for the PPS test datapath (clock wizard plus PPS generator). On a software arm request it holds the clock wizard and PPS generator in reset, releases them, waits for MMCM lock and a settle interval, then qualifies the PPS pulse train. Qualified pulses are forwarded to the output pin. A sticky fault is raised on lock loss or a PPS period outside tolerance. It sits in the 100 MHz domain beside the clock wizard/PPS generator pair and drives their shared active-high `areset`.

## Interface
- `RESET_CYCLES`, 16: cycles `gen_reset` is held after arm.
- `LOCK_TIMEOUT`, 10_000_000: max cycles in WAIT_LOCK before fault.
- `SETTLE_CYCLES`, 1_000_000: cycles lock must stay continuously high before PPS qualification starts.
- `PPS_PERIOD`, 100_000_000: nominal cycles between PPS rising edges.
- `PPS_TOL`, 1_000: allowed ± deviation in cycles.
- `clk100MHz` in 1: sole clock.
- `areset_n` in 1: asynchronous, active-low reset.
- `mmcm_locked` in 1: clock wizard lock. Asynchronous; synchronized internally with 2 FFs.
- `arm` in 1: level request. 1 = bring up and run, 0 = shut down.
- `pps_in` in 1: raw PPS from the generator, synchronous to `clk100MHz`.
- `gen_reset` out 1: active-high reset to the clock wizard and PPS generator.
- `pps_out` out 1: qualified PPS.
- `state` out 3: current FSM state encoding.
- `fault` out 1: sticky fault flag.
- `pps_count` out 32: accepted PPS edges since the last IDLE.

## Operation
- States and encoding: IDLE=0, RESET=1, WAIT_LOCK=2, SETTLE=3, WAIT_PPS=4, RUN=5, FAULT=6.
- Reset values: state=IDLE, `gen_reset`=1, `pps_out`=0, `fault`=0, `pps_count`=0. All counters are 0.
- Transition priority, every cycle: `arm`=0 → IDLE. This beats lock loss, which beats timeout, which beats edge events.
- IDLE
  - `gen_reset`=1, `fault` cleared, `pps_count` cleared.
  - `arm`=1 → RESET.
- RESET
  - `gen_reset`=1 for exactly RESET_CYCLES cycles, then → WAIT_LOCK.
- WAIT_LOCK
  - `gen_reset`=0.
  - Synchronized lock =1 → SETTLE.
  - LOCK_TIMEOUT cycles elapse → FAULT.
- SETTLE
  - Counts SETTLE_CYCLES with lock high, then → WAIT_PPS.
  - Lock drop → WAIT_LOCK, with the settle counter cleared and the lock timeout restarted.
- WAIT_PPS
  - First `pps_in` rising edge → RUN and clears the interval counter. This edge is not forwarded.
  - No edge within PPS_PERIOD+PPS_TOL cycles → FAULT.
  - Lock drop → FAULT.
- RUN
  - Each rising edge checks interval counter I against PPS_PERIOD−PPS_TOL ≤ I ≤ PPS_PERIOD+PPS_TOL.
  - Pass: clear I, increment `pps_count` (wraps modulo 2^32), forward the pulse.
  - Fail, or I reaching PPS_PERIOD+PPS_TOL+1 with no edge: → FAULT.
  - Lock drop → FAULT.
- FAULT
  - `fault`=1, `gen_reset`=1, `pps_out`=0.
  - Held until `arm`=0, which goes to IDLE. Re-arming requires an `arm` 0→1 cycle.
- Forwarding
  - A pass flag is set by an accepted edge and cleared when `pps_in` falls or on leaving RUN.
  - A pulse is truncated immediately on leaving RUN.
- Interval counter: 32 bits, saturating, counts every cycle in WAIT_PPS/RUN.

## Timing
- Edge detect uses a registered `pps_in` (`pps_q`): edge = `pps_in` & ~`pps_q`.
- `pps_out` latency: `pps_out`(t+1) = `pps_in`(t) & pass. The rising edge appears 1 cycle after `pps_in` rises, and the falling edge 1 cycle after `pps_in` falls.
- `mmcm_locked` to internal lock: 2 cycles of synchronizer latency.
- All outputs are registered; `state` changes 1 cycle after the qualifying input.
- `gen_reset` deasserts on the first cycle of WAIT_LOCK, i.e. RESET_CYCLES+1 cycles after `arm` is sampled high in IDLE.
- `areset_n` assertion mid-operation immediately forces all reset values; release is synchronous to the next clock edge.

## Structure
- Package `pps_ctrl_pkg`: state enum with the fixed 3-bit encoding, and default parameter constants.
- Sub-module `sync_2ff`: generic 2-FF synchronizer, reset to 0 by `areset_n`, used for `mmcm_locked`.

## Test plan
All scenarios use RESET_CYCLES=4, LOCK_TIMEOUT=50, SETTLE_CYCLES=20, PPS_PERIOD=100, PPS_TOL=5.
- Nominal bring-up:
  - Stimulus: `arm`=1, lock 10 cycles after release, PPS edges every 100 cycles.
  - Response: `gen_reset` high for 5 cycles; state sequence IDLE→RESET→WAIT_LOCK→SETTLE→WAIT_PPS→RUN; first edge not forwarded; later edges forwarded with 1-cycle lag; `pps_count` = 3 after 3 further edges.
- Tolerance boundaries: edge intervals of 95 and 105 are accepted; an interval of 94 → FAULT with `fault`=1 and `pps_out`=0; separately, no edge for 106 cycles → FAULT.
- Lock behaviour: lock drop during SETTLE returns to WAIT_LOCK and the full 20-cycle settle is needed again; lock drop in RUN → FAULT; lock never asserted → FAULT after 50 cycles.
- Arm handling: `arm`=0 mid-RUN during a high PPS pulse → `pps_out` low next cycle, state IDLE, `gen_reset`=1, `pps_count`=0; `arm` held high in FAULT stays in FAULT.
- Async reset: `areset_n` pulsed low in RUN → all outputs take reset values without waiting for a clock edge; system stays in IDLE until `arm` is sampled.
- Wrap: preload `pps_count`=0xFFFF_FFFF by force, then one accepted edge → 0x0000_0000 with no fault.
